// File: rtl/sqrt_gen.sv
// rtl/sqrt_gen.sv - sequential digit-by-digit integer square root, floor or round-to-nearest
module sqrt_gen #(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   valor,
  input  logic               round_en,
  output logic               ready,
  output logic               endop,
  output logic [WIDTH/2-1:0] sqrt,
  output logic [WIDTH/2:0]   rem,
  output logic               sat
);

  localparam int N  = WIDTH / 2;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  // Operand copy shifted left two bits per step; top pair feeds the next digit.
  logic [WIDTH-1:0] data_q;
  logic [N-1:0]     root_q;
  logic [N:0]       rem_q;
  logic [CW-1:0]    cnt_q;
  logic             mode_q;

  logic [N+2:0]     trial_rem;
  logic [N+2:0]     trial_sub;
  logic             digit;
  logic [N-1:0]     root_nx;
  logic [N:0]       rem_nx;
  logic             last_iter;
  logic             round_up;
  logic             sat_nx;
  logic [N-1:0]     sqrt_nx;

  // One restoring step: try subtracting (4*root + 1) from the shifted-in remainder.
  always_comb begin
    trial_rem = {rem_q, data_q[WIDTH-1 -: 2]};
    trial_sub = {1'b0, root_q, 2'b01};
    digit     = (trial_rem >= trial_sub);
    root_nx   = {root_q[N-2:0], digit};
    // Final remainder never exceeds 2*root, so the low N+1 bits carry the exact difference.
    rem_nx    = digit ? (trial_rem[N:0] - trial_sub[N:0]) : trial_rem[N:0];
    last_iter = (cnt_q == CW'(N - 1));
    // Rounding: root+1 is nearer whenever the floor remainder exceeds the floor root.
    round_up  = mode_q && (rem_nx > {1'b0, root_nx});
    sat_nx    = round_up && (&root_nx);
    sqrt_nx   = (round_up && !sat_nx) ? (root_nx + 1'b1) : root_nx;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    endop    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_nx = CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        endop    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      root_q <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      sqrt   <= '0;
      rem    <= '0;
      sat    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            data_q <= valor;
            mode_q <= round_en;
            root_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
          end
        end
        CALC: begin
          data_q <= {data_q[WIDTH-3:0], 2'b00};
          root_q <= root_nx;
          rem_q  <= rem_nx;
          cnt_q  <= cnt_q + 1'b1;
          if (last_iter) begin
            sqrt <= sqrt_nx;
            rem  <= rem_nx;
            sat  <= sat_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_gen.sv
// tb/tb_sqrt_gen.sv - directed and reference-model bench for sqrt_gen
module tb_sqrt_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        st16, m16, rdy16, end16, sat16;
  logic [15:0] v16;
  logic [7:0]  q16;
  logic [8:0]  rm16;

  logic        st8, m8, rdy8, end8, sat8;
  logic [7:0]  v8;
  logic [3:0]  q8;
  logic [4:0]  rm8;

  logic        st32, m32, rdy32, end32, sat32;
  logic [31:0] v32;
  logic [15:0] q32;
  logic [16:0] rm32;

  sqrt_gen #(.WIDTH(16)) u16 (
    .clock(clk), .reset(rst_n), .start(st16), .valor(v16), .round_en(m16),
    .ready(rdy16), .endop(end16), .sqrt(q16), .rem(rm16), .sat(sat16)
  );

  sqrt_gen #(.WIDTH(8)) u8 (
    .clock(clk), .reset(rst_n), .start(st8), .valor(v8), .round_en(m8),
    .ready(rdy8), .endop(end8), .sqrt(q8), .rem(rm8), .sat(sat8)
  );

  sqrt_gen #(.WIDTH(32)) u32 (
    .clock(clk), .reset(rst_n), .start(st32), .valor(v32), .round_en(m32),
    .ready(rdy32), .endop(end32), .sqrt(q32), .rem(rm32), .sat(sat32)
  );

  typedef struct {
    logic [15:0] v;
    logic        m;
    logic [7:0]  es;
    logic [8:0]  er;
    logic        esat;
  } vec_t;

  vec_t vecs[15];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void ref_sqrt(input longint unsigned v, input int n, input bit m,
                                   output longint unsigned s, output longint unsigned r,
                                   output bit sat);
    longint unsigned q = 0;
    longint unsigned t;
    for (int b = n - 1; b >= 0; b--) begin
      t = q | (64'd1 << b);
      if (t * t <= v) q = t;
    end
    r   = v - q * q;
    s   = q;
    sat = 1'b0;
    if (m && r > q) begin
      if (q + 1 == (64'd1 << n)) sat = 1'b1;
      else s = q + 1;
    end
  endfunction

  task automatic op16(input logic [15:0] v, input logic m, input bit disturb,
                      input longint es, input longint er, input longint esat);
    int lat = -1;
    int busy_bad = 0;
    chk($sformatf("w16_ready_idle v=%0d", v), rdy16, 1);
    st16 = 1'b1; v16 = v; m16 = m;
    @(posedge clk); #1;
    st16 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (rdy16) busy_bad++;
      if (disturb) begin
        v16  = 16'($urandom);
        m16  = ~m16;
        st16 = 1'b1;
      end
      @(posedge clk); #1;
      if (end16) begin
        lat = k;
        break;
      end
    end
    st16 = 1'b0;
    if (rdy16) busy_bad++;
    chk($sformatf("w16_busy_ready v=%0d", v), busy_bad, 0);
    chk($sformatf("w16_latency v=%0d", v), lat, 8);
    chk($sformatf("w16_sqrt v=%0d m=%0d", v, m), q16, es);
    chk($sformatf("w16_rem v=%0d m=%0d", v, m), rm16, er);
    chk($sformatf("w16_sat v=%0d m=%0d", v, m), sat16, esat);
    @(posedge clk); #1;
    chk($sformatf("w16_endop_pulse v=%0d", v), end16, 0);
    chk($sformatf("w16_hold_sqrt v=%0d", v), q16, es);
  endtask

  task automatic op8(input logic [7:0] v, input bit m);
    longint unsigned es, er;
    bit esat;
    int lat = -1;
    ref_sqrt(64'(v), 4, m, es, er, esat);
    st8 = 1'b1; v8 = v; m8 = m;
    @(posedge clk); #1;
    st8 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (end8) begin
        lat = k;
        break;
      end
    end
    chk($sformatf("w8_latency v=%0d", v), lat, 4);
    chk($sformatf("w8_sqrt v=%0d m=%0d", v, m), q8, longint'(es));
    chk($sformatf("w8_rem v=%0d m=%0d", v, m), rm8, longint'(er));
    chk($sformatf("w8_sat v=%0d m=%0d", v, m), sat8, esat);
    @(posedge clk); #1;
  endtask

  task automatic op32(input logic [31:0] v, input bit m);
    longint unsigned es, er;
    bit esat;
    int lat = -1;
    ref_sqrt(64'(v), 16, m, es, er, esat);
    st32 = 1'b1; v32 = v; m32 = m;
    @(posedge clk); #1;
    st32 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (end32) begin
        lat = k;
        break;
      end
    end
    chk($sformatf("w32_latency v=%0d", v), lat, 16);
    chk($sformatf("w32_sqrt v=%0d m=%0d", v, m), q32, longint'(es));
    chk($sformatf("w32_rem v=%0d m=%0d", v, m), rm32, longint'(er));
    chk($sformatf("w32_sat v=%0d m=%0d", v, m), sat32, esat);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc, last, spacing_bad, ends, stray;
    bit was_rdy;

    vecs[0]  = '{16'd4,     1'b0, 8'd2,   9'd0,   1'b0};
    vecs[1]  = '{16'd16,    1'b0, 8'd4,   9'd0,   1'b0};
    vecs[2]  = '{16'd0,     1'b0, 8'd0,   9'd0,   1'b0};
    vecs[3]  = '{16'd65535, 1'b0, 8'd255, 9'd510, 1'b0};
    vecs[4]  = '{16'd8,     1'b1, 8'd3,   9'd4,   1'b0};
    vecs[5]  = '{16'd6,     1'b1, 8'd2,   9'd2,   1'b0};
    vecs[6]  = '{16'd65535, 1'b1, 8'd255, 9'd510, 1'b1};
    vecs[7]  = '{16'd15,    1'b1, 8'd4,   9'd6,   1'b0};
    vecs[8]  = '{16'd24,    1'b1, 8'd5,   9'd8,   1'b0};
    vecs[9]  = '{16'd20,    1'b1, 8'd4,   9'd4,   1'b0};
    vecs[10] = '{16'd65025, 1'b1, 8'd255, 9'd0,   1'b0};
    vecs[11] = '{16'd99,    1'b0, 8'd9,   9'd18,  1'b0};
    vecs[12] = '{16'd100,   1'b0, 8'd10,  9'd0,   1'b0};
    vecs[13] = '{16'd1,     1'b1, 8'd1,   9'd0,   1'b0};
    vecs[14] = '{16'd0,     1'b1, 8'd0,   9'd0,   1'b0};

    rst_n = 1'b0;
    st16 = 1'b0; v16 = '0; m16 = 1'b0;
    st8  = 1'b0; v8  = '0; m8  = 1'b0;
    st32 = 1'b0; v32 = '0; m32 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_sqrt", q16, 0);
    chk("reset_rem", rm16, 0);
    chk("reset_sat", sat16, 0);
    chk("reset_endop", end16, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_ready", rdy16, 1);

    for (int i = 0; i < 15; i++) begin
      op16(vecs[i].v, vecs[i].m, 1'b0, vecs[i].es, vecs[i].er, vecs[i].esat);
    end

    op16(16'd50, 1'b0, 1'b1, 7, 1, 0);

    st16 = 1'b1; v16 = 16'd100; m16 = 1'b0;
    acc = 0; last = -100; spacing_bad = 0; ends = 0;
    for (int i = 0; i < 40; i++) begin
      was_rdy = rdy16;
      @(posedge clk); #1;
      if (was_rdy) begin
        if (acc > 0 && (i - last) != 10) spacing_bad++;
        last = i;
        acc++;
      end
      if (end16) begin
        ends++;
        chk($sformatf("held_sqrt i=%0d", i), q16, 10);
      end
    end
    st16 = 1'b0;
    chk("held_accepts", acc, 4);
    chk("held_spacing", spacing_bad, 0);
    chk("held_endops", ends, 4);
    repeat (12) @(posedge clk);
    #1;

    chk("abort_ready_before", rdy16, 1);
    st16 = 1'b1; v16 = 16'd225; m16 = 1'b0;
    @(posedge clk); #1;
    st16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_sqrt", q16, 0);
    chk("abort_rem", rm16, 0);
    chk("abort_sat", sat16, 0);
    chk("abort_endop", end16, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_ready_after", rdy16, 1);
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (end16) stray++;
    end
    chk("abort_no_endop", stray, 0);
    op16(16'd225, 1'b0, 1'b0, 15, 0, 0);

    op8(8'd0, 1'b0);
    op8(8'd255, 1'b0);
    op8(8'd255, 1'b1);
    op8(8'd224, 1'b1);
    for (int i = 0; i < 20; i++) begin
      op8(8'($urandom), 1'b0);
      op8(8'($urandom), 1'b1);
    end

    op32(32'd0, 1'b0);
    op32(32'hFFFF_FFFF, 1'b0);
    op32(32'hFFFF_FFFF, 1'b1);
    op32(32'hFFFE_0001, 1'b1);
    for (int i = 0; i < 20; i++) begin
      op32($urandom, 1'b0);
      op32($urandom, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
